// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-precision ALU sequencer and its 8-bit slice.
package alu_seq_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_RSUB = 3'd2,
        OP_OR   = 3'd3,
        OP_AND  = 3'd4,
        OP_ANDN = 3'd5,
        OP_XOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu8_slice.sv
// Combinational 8-bit ALU byte slice; produces a 9-bit {carry, sum} per byte.
module alu8_slice
    import alu_seq_pkg::*;
(
    input  op_t               i_op,
    input  logic [BYTE_W-1:0] i_a8,
    input  logic [BYTE_W-1:0] i_b8,
    input  logic              i_cin,
    input  logic              i_first,
    output logic [BYTE_W-1:0] o_sum8,
    output logic              o_cout
);

    logic [BYTE_W:0] w_full;
    logic            w_cin_eff;

    // RSUB inverts the carry only on the least significant byte; upper bytes take the raw ripple carry.
    always_comb begin
        w_full    = '0;
        if (i_first && (i_op == OP_RSUB)) begin
            w_cin_eff = ~i_cin;
        end else begin
            w_cin_eff = i_cin;
        end
        case (i_op)
            OP_ADD:  w_full = {1'b0, i_a8} + {1'b0, i_b8} + {{BYTE_W{1'b0}}, w_cin_eff};
            OP_SUB:  w_full = {1'b0, i_a8} + {1'b0, ~i_b8} + {{BYTE_W{1'b0}}, w_cin_eff};
            OP_RSUB: w_full = {1'b0, ~i_a8} + {1'b0, i_b8} + {{BYTE_W{1'b0}}, w_cin_eff};
            OP_OR:   w_full = {1'b0, i_a8 | i_b8};
            OP_AND:  w_full = {1'b0, i_a8 & i_b8};
            OP_ANDN: w_full = {1'b0, ~i_a8 & i_b8};
            OP_XOR:  w_full = {1'b0, i_a8 ^ i_b8};
            OP_XNOR: w_full = {1'b0, ~(i_a8 ^ i_b8)};
            default: w_full = '0;
        endcase
        o_sum8 = w_full[BYTE_W-1:0];
        o_cout = w_full[BYTE_W];
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Runs one NBYTES-wide ALU operation through a single byte slice, LSB first,
// rippling the carry between bytes and registering result/flags at the end.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int CW     = $clog2(NBYTES) + 1,
    localparam int W     = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         c_out,
    output logic         zero
);

    state_t            r_state;
    op_t               r_op;
    logic [CW-1:0]     r_cnt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_acc;
    logic [W-1:0]      r_result;
    logic              r_carry;
    logic              r_busy;
    logic              r_done;
    logic              r_c_out;
    logic              r_zero;

    logic [31:0]       w_lo;
    logic [BYTE_W-1:0] w_a8;
    logic [BYTE_W-1:0] w_b8;
    logic [BYTE_W-1:0] w_sum8;
    logic              w_cout;
    logic              w_first;
    logic              w_last;
    logic [W-1:0]      w_acc_next;

    // Select the current byte and merge the slice output into its accumulator slot (slot is zero until written).
    always_comb begin
        w_lo       = 32'(r_cnt) * BYTE_W;
        w_a8       = BYTE_W'(r_a >> w_lo);
        w_b8       = BYTE_W'(r_b >> w_lo);
        w_first    = (r_cnt == '0);
        w_last     = (r_cnt == CW'(NBYTES - 1));
        w_acc_next = r_acc | (W'(w_sum8) << w_lo);
    end

    alu8_slice u_slice (
        .i_op    (r_op),
        .i_a8    (w_a8),
        .i_b8    (w_b8),
        .i_cin   (r_carry),
        .i_first (w_first),
        .o_sum8  (w_sum8),
        .o_cout  (w_cout)
    );

    // Sequencer FSM: latch command in IDLE, one byte per cycle in RUN, one-cycle DONE pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_c_out  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op_t'(op);
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_result <= w_acc_next;
                        r_c_out  <= w_cout;
                        r_zero   <= (w_acc_next == '0);
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign c_out  = r_c_out;
    assign zero   = r_zero;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (NBYTES=4): vector table plus scoreboard queue.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         c_in  = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         zero;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .c_in   (c_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .zero   (zero)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         z;
    } exp_t;

    exp_t         exp_q[$];
    vec_t         vecs[14];
    int           n_checks    = 0;
    int           n_errors    = 0;
    int           n_dones     = 0;
    logic [W-1:0] last_result = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pops one expected record; a done with nothing queued is an error.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_dones++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done with result 0x%0h, expected no done", result);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("c_out", c_out, e.co);
                chk("zero", zero, {{(W-1){1'b0}}, e.z});
            end
        end
    end

    task automatic run_op(input logic [2:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic cin_v, input logic [W-1:0] res_v, input logic co_v);
        int   edges;
        int   busy_cnt;
        logic got;
        exp_q.push_back('{res_v, co_v, (res_v == '0)});
        @(negedge clk);
        start = 1'b1; op = op_v; a = a_v; b = b_v; c_in = cin_v;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after acceptance; the latched command must be unaffected.
        start = 1'b0; op = op_v ^ 3'd1; a = ~a_v; b = ~b_v; c_in = ~cin_v;
        edges = 1; busy_cnt = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
            chk("result_hold", result, last_result);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done in 20 cycles, expected done");
        end else begin
            chk("latency_edges", edges, NBYTES + 1);
            chk("busy_cycles", busy_cnt, NBYTES + 1);
        end
        last_result = res_v;
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
        chk("done_single_cycle", done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   d0;
        logic got;

        vecs[0]  = '{3'd0, 32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0};
        vecs[1]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[2]  = '{3'd1, 32'h10000000, 32'h00000001, 1'b1, 32'h0FFFFFFF, 1'b1};
        vecs[3]  = '{3'd1, 32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{3'd2, 32'h00000003, 32'h00000005, 1'b0, 32'h00000002, 1'b1};
        vecs[5]  = '{3'd2, 32'h00000003, 32'h00000005, 1'b1, 32'h00000001, 1'b1};
        vecs[6]  = '{3'd2, 32'h00000005, 32'h00000003, 1'b0, 32'hFFFFFFFE, 1'b0};
        vecs[7]  = '{3'd0, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
        vecs[8]  = '{3'd3, 32'h12340000, 32'h00005678, 1'b1, 32'h12345678, 1'b0};
        vecs[9]  = '{3'd4, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 32'h0F000F00, 1'b0};
        vecs[10] = '{3'd7, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b0};
        vecs[11] = '{3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 1'b0};
        vecs[12] = '{3'd5, 32'h0F0F0F0F, 32'hFFFF0000, 1'b1, 32'hF0F00000, 1'b0};
        vecs[13] = '{3'd1, 32'h00000005, 32'h00000005, 1'b0, 32'hFFFFFFFF, 1'b0};

        #12;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, '0);
        chk("reset_c_out", c_out, 1'b0);
        chk("reset_zero", zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].co);
        end

        // Start pulsed in RUN with different operands must be ignored.
        exp_q.push_back('{32'h0FF00FF0, 1'b0, 1'b0});
        d0 = n_dones;
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'hF0F0F0F0; b = 32'hFF00FF00; c_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'h00000001; b = 32'h00000001;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_ignored_start", busy, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ignored_start_done_seen", got, 1'b1);
        repeat (10) @(negedge clk);
        chk("ignored_start_done_count", n_dones - d0, 1);
        last_result = 32'h0FF00FF0;

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'h12345678; b = 32'h11111111; c_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d0 = n_dones;
        rst_n = 1'b0;
        #1;
        chk("abort_result", result, '0);
        chk("abort_c_out", c_out, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", n_dones - d0, 0);
        last_result = '0;
        run_op(3'd5, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 32'hF0F0F0F0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-precision sequencer for the team's 8-bit ALU byte slice.
- Accepts one NBYTES-wide operation and runs it through a single 8-bit slice, one byte per cycle, LSB first.
- Propagates carry between bytes and returns the full-width result with carry-out and zero flags.
- Sits between the command source (testbench or control FSM) and the shared byte-slice datapath.

Parameters:
- NBYTES, 4, operand width in bytes (≥1); full width W = 8*NBYTES.
- CW, $clog2(NBYTES)+1, width of the internal byte counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  command request; accepted only in IDLE
- op  input  3  0 ADD (a+b+cin), 1 SUB (a+~b+cin), 2 RSUB (~a+b+~cin), 3 OR, 4 AND, 5 ANDN (~a&b), 6 XOR, 7 XNOR
- a  input  W  operand A
- b  input  W  operand B
- c_in  input  1  initial carry
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when result valid
- result  output  W  final result
- c_out  output  1  final carry
- zero  output  1  result==0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, c_out, zero =0; result=0; internal operand/counter registers cleared.
- IDLE: when start=1 at edge T, latch op, a, b, c_in; counter=0; go to RUN. busy rises at T+1.
- RUN: at edge T+k (k=1..NBYTES), byte k-1 is computed and stored in the internal accumulator.
  - Byte slice inputs: a[8(k-1)+:8], b[8(k-1)+:8], carry-in.
  - Carry-in for byte 0: c_in for ADD/SUB, ~c_in for RSUB.
  - Carry-in for byte j>0: carry-out of byte j-1, not re-inverted for RSUB.
  - Logic ops (3–7): carry forced to 0.
- After byte NBYTES-1 (edge T+NBYTES):
  - Go to DONE.
  - result ← accumulator; c_out ← final carry (0 for logic ops); zero ← (result==0).
  - done=1 during the cycle after edge T+NBYTES; done is low at all other times.
- DONE: lasts exactly one cycle, then IDLE.
- Latency: start edge to done-high cycle = NBYTES+1 edges. Throughput: one op per NBYTES+2 cycles.
- result, c_out and zero hold their last values until the next DONE; they do not change during RUN.
- start while busy=1 (RUN or DONE) is ignored: no queuing, latched operands unchanged.
- Input changes on a/b/op/c_in after acceptance have no effect.
- Reset mid-RUN aborts immediately: outputs return to reset values and no done is produced. The next start after rst_n deasserts behaves normally.
- NBYTES=1: RUN lasts one cycle. The carry chain reduces to byte 0.
- Width rules: each slice is a 9-bit sum {cout, sum[7:0]}. Bit 8 is the inter-byte carry. There is no overflow flag.

Decomposition:
- Package alu_seq_pkg:
  - op_t enum (ADD, SUB, RSUB, OR, AND, ANDN, XOR, XNOR, 3-bit).
  - state_t enum (IDLE, RUN, DONE).
  - Constant BYTE_W=8.
- Sub-module alu8_slice:
  - Purely combinational.
  - Inputs: op, a8, b8, cin. Outputs: sum8, cout.
  - Implements the eight operations exactly as listed under op, including internal ~cin for RSUB byte 0 only. The controller passes a first-byte flag.
- Top-level: FSM, counter, operand registers, accumulator and output registers.

Test Plan (NBYTES=4):
- ADD a=0x00FFFFFF, b=0x00000001, c_in=0 → result=0x01000000, c_out=0, zero=0; done high exactly 5 edges after start; busy high for 5 cycles.
- ADD a=0xFFFFFFFF, b=0x00000001, c_in=0 → result=0x00000000, c_out=1, zero=1.
- SUB a=0x10000000, b=0x00000001, c_in=1 → result=0x0FFFFFFF, c_out=1. Separately, SUB a=1, b=2, c_in=1 → result=0xFFFFFFFF, c_out=0.
- RSUB a=0x00000003, b=0x00000005, c_in=0 → result=0x00000002, c_out=1.
- XOR a=0xF0F0F0F0, b=0xFF00FF00 → result=0x0FF00FF0, c_out=0. A second start pulsed during RUN with different operands is ignored: exactly one done and the first result.
- Start ADD, assert rst_n=0 at RUN cycle 2 → result=0, c_out=0, busy=0, no done. After release, ANDN a=0x0F0F0F0F, b=0xFFFFFFFF → result=0xF0F0F0F0, c_out=0.
